// File: rtl/register_bank.sv
// MIPS general-purpose register file. It has a one-hot write port driven by the 5-to-32 decoder
// and two combinational read ports, with optional same-cycle forwarding.
module register_bank #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WriteEn,
  input  logic [NREGS-1:0]  WriteSel,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              SelError,
  output logic [CNT_W-1:0]  WriteCount
);

  logic [WIDTH-1:0]  regs [NREGS];
  logic              wr_legal;
  logic [ADDR_W-1:0] wr_idx;
  logic              byp_ok;

  function automatic logic is_onehot(input logic [NREGS-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  // OR of the indices of all set bits; exact only when sel is one-hot, which is the only case it is used
  function automatic logic [ADDR_W-1:0] encode(input logic [NREGS-1:0] sel);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREGS; k++)
      if (sel[k]) idx = idx | ADDR_W'(k);
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  assign wr_legal = is_onehot(WriteSel);
  assign wr_idx   = encode(WriteSel);
  // Forwarding is masked during reset so the read ports return zero while reset is held
  assign byp_ok   = (BYPASS != 0) && !reset && WriteEn && wr_legal;

  // An unknown WriteSel makes the legality test fail, which takes the error branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      SelError   <= 1'b0;
      WriteCount <= '0;
    end else if (WriteEn) begin
      if (wr_legal) begin
        if (wr_idx != '0) begin
          regs[wr_idx] <= WriteData;
          WriteCount   <= sat_inc(WriteCount);
        end
      end else begin
        SelError <= 1'b1;
      end
    end
  end

  always_comb begin
    ReadData1 = regs[ReadAddr1];
    if (ReadAddr1 == '0)
      ReadData1 = '0;
    else if (byp_ok && (wr_idx == ReadAddr1))
      ReadData1 = WriteData;
  end

  always_comb begin
    ReadData2 = regs[ReadAddr2];
    if (ReadAddr2 == '0)
      ReadData2 = '0;
    else if (byp_ok && (wr_idx == ReadAddr2))
      ReadData2 = WriteData;
  end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank. It runs a forwarding instance with a 16-bit counter and a
// non-forwarding instance with a 4-bit counter side by side on the same stimulus.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        WriteEn;
  logic [31:0] WriteSel;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        err, err_nb;
  logic [15:0] cnt;
  logic [3:0]  cnt_nb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic        m_err;
  int          m_cnt, m_cnt4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } item_t;
  item_t sb_q[$];

  always #5 clk = ~clk;

  register_bank #(.WIDTH(32), .NREGS(32), .ADDR_W(5), .BYPASS(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .WriteEn(WriteEn), .WriteSel(WriteSel), .WriteData(WriteData),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .ReadData1(rd1), .ReadData2(rd2),
    .SelError(err), .WriteCount(cnt));

  register_bank #(.WIDTH(32), .NREGS(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) u_nb (
    .clk(clk), .reset(reset), .WriteEn(WriteEn), .WriteSel(WriteSel), .WriteData(WriteData),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .ReadData1(rd1_nb), .ReadData2(rd2_nb),
    .SelError(err_nb), .WriteCount(cnt_nb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int popcount(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic bit legal(input logic [31:0] v);
    return (popcount(v) == 1) && !$isunknown(v);
  endfunction

  function automatic int set_bit(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i] === 1'b1) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && !reset && WriteEn && legal(WriteSel) && set_bit(WriteSel) == int'(a))
      return WriteData;
    return m_regs[a];
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      0: return "rd1_byp";
      1: return "rd2_byp";
      2: return "rd1_nb";
      3: return "rd2_nb";
      4: return "selerr";
      5: return "selerr_nb";
      6: return "cnt16";
      default: return "cnt4";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int k);
    case (k)
      0: return rd1;
      1: return rd2;
      2: return rd1_nb;
      3: return rd2_nb;
      4: return {31'd0, err};
      5: return {31'd0, err_nb};
      6: return {16'd0, cnt};
      default: return {28'd0, cnt_nb};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  // Drive read addresses, queue the expected outputs, then drain the queue once outputs settle
  task automatic expect_all(input logic [4:0] a1, input logic [4:0] a2);
    item_t it;
    ReadAddr1 = a1;
    ReadAddr2 = a2;
    sb_q.push_back('{0, model_read(a1, 1)});
    sb_q.push_back('{1, model_read(a2, 1)});
    sb_q.push_back('{2, model_read(a1, 0)});
    sb_q.push_back('{3, model_read(a2, 0)});
    sb_q.push_back('{4, {31'd0, m_err}});
    sb_q.push_back('{5, {31'd0, m_err}});
    sb_q.push_back('{6, 32'(m_cnt)});
    sb_q.push_back('{7, 32'(m_cnt4)});
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check($sformatf("%s a1=%0d a2=%0d", kind_name(it.kind), a1, a2), observe(it.kind), it.exp);
    end
  endtask

  task automatic do_edge();
    @(posedge clk);
    if (!reset && WriteEn) begin
      if (legal(WriteSel)) begin
        if (set_bit(WriteSel) != 0) begin
          m_regs[set_bit(WriteSel)] = WriteData;
          if (m_cnt != 65535) m_cnt++;
          if (m_cnt4 != 15) m_cnt4++;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [31:0] sel, input logic [31:0] data);
    WriteEn   = en;
    WriteSel  = sel;
    WriteData = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    ReadAddr1 = '0;
    ReadAddr2 = '0;
    model_reset();
    @(negedge clk);
    expect_all(5'd5, 5'd31);
    @(negedge clk);
    reset = 1'b0;

    // R5 write; the forwarding port sees it before the edge, the other only after
    drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    expect_all(5'd5, 5'd0);
    do_edge();
    drive(1'b0, 32'h0, 32'h0);
    expect_all(5'd5, 5'd5);

    drive(1'b1, 32'h8000_0000, 32'h1234_5678);
    expect_all(5'd5, 5'd31);
    do_edge();
    expect_all(5'd5, 5'd31);

    // A write to R0 is discarded silently
    drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
    expect_all(5'd0, 5'd0);
    do_edge();
    drive(1'b0, 32'h0, 32'h0);
    expect_all(5'd0, 5'd31);

    // Illegal selects set the sticky error; with the write disabled, the select is ignored
    drive(1'b1, 32'h0000_0006, 32'h5555_AAAA);
    expect_all(5'd1, 5'd2);
    do_edge();
    expect_all(5'd1, 5'd2);
    drive(1'b1, 32'h0000_0000, 32'h5555_AAAA);
    do_edge();
    expect_all(5'd1, 5'd2);
    drive(1'b0, 32'hF000_000F, 32'h7777_7777);
    do_edge();
    expect_all(5'd3, 5'd28);

    // Write every register with decoder-style one-hot selects, then read each one back on both ports
    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 32'd1 << k, $urandom);
      do_edge();
    end
    drive(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      expect_all(5'(k), 5'(k));
    end

    // Counter saturation, with R3 holding the final value
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_0008, 32'hC0DE_0000 + i);
      do_edge();
    end
    drive(1'b0, 32'h0, 32'h0);
    expect_all(5'd3, 5'd3);

    // Assert reset mid-run with a write pending; it wins immediately and clears everything
    drive(1'b1, 32'h0000_0080, 32'hAAAA_5555);
    #1;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 32; k++) begin
      expect_all(5'(k), 5'(31 - k));
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    expect_all(5'd7, 5'd5);

    drive(1'b1, 32'h0000_0200, 32'h0BAD_F00D);
    do_edge();
    drive(1'b0, 32'h0, 32'h0);
    expect_all(5'd9, 5'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
